motor_pwm_ramp: RTL and testbench



---
 rtl/motor_pkg.sv | 23 ++
 rtl/motor_pwm_chan.sv | 140 ++++++++++++++
 rtl/motor_pwm_ramp.sv | 82 ++++++++
 tb/tb_motor_pwm_ramp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and constants for the motor PWM ramp block.
package motor_pkg;

    // Per-channel control state.
    typedef enum logic [1:0] {
        StIdle,
        StRamp,
        StRun,
        StDead
    } chan_state_t;

    // Bridge pair encodings: {IN_hi, IN_lo}.
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_OFF   = 2'b00;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    // Only the two half-bridge-exclusive patterns count as a drive request.
    function automatic logic dir_valid(input logic [1:0] pair);
        return (pair == DIR_FWD) || (pair == DIR_REV);
    endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One bridge channel: soft-start duty ramp, run, and dead-time on reversal.
// Optional build macro MOTOR_BRAKE_EN: the dead interval actively brakes
// (pair 11, pwm 1) instead of coasting (pair 00, pwm 0).
module motor_pwm_chan
    import motor_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned RAMP_STEP   = 16,
    parameter int unsigned DEAD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       pair_req,
    input  logic [CNT_W-1:0] duty_target,
    input  logic             tick,
    input  logic [CNT_W-1:0] cnt_next,
    output logic             pwm,
    output logic [1:0]       bridge,
    output logic             busy
);

    localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);

    chan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [1:0]        dir_q, dir_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              pwm_d, busy_d;
    logic [1:0]        bridge_d;
    logic              req;
    logic [31:0]       ramp_sum;

    assign req      = en && dir_valid(pair_req);
    // Wide sum so the step can never wrap past the top of the duty range.
    assign ramp_sum = 32'(duty_q) + 32'(RAMP_STEP);

    // Next-state: off beats reversal, reversal beats any target change.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        unique case (state_q)
            StIdle: begin
                duty_d = '0;
                if (req) begin
                    state_d = StRamp;
                    dir_d   = pair_req;
                end
            end
            StRamp, StRun: begin
                if (!req) begin
                    state_d = StIdle;
                    duty_d  = '0;
                end else if (pair_req != dir_q) begin
                    state_d = StDead;
                    duty_d  = '0;
                    // Loaded one short so the pair is off for exactly DEAD_CYCLES cycles.
                    dead_d  = DEAD_W'(DEAD_CYCLES - 1);
                end else if (state_q == StRamp) begin
                    if (duty_q == duty_target) begin
                        state_d = StRun;
                    end else if (tick) begin
                        duty_d = (ramp_sum >= 32'(duty_target)) ? duty_target
                                                                : ramp_sum[CNT_W-1:0];
                    end
                end else begin
                    if (duty_target > duty_q) begin
                        state_d = StRamp;
                    end else if (duty_target < duty_q) begin
                        duty_d = duty_target;
                    end
                end
            end
            StDead: begin
                duty_d = '0;
                if (dead_q == '0) begin
                    if (req) begin
                        state_d = StRamp;
                        dir_d   = pair_req;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so outputs are registered with no extra lag.
    always_comb begin
        pwm_d    = 1'b0;
        bridge_d = DIR_OFF;
        busy_d   = 1'b0;
        case (state_d)
            StRamp: begin
                bridge_d = dir_d;
                pwm_d    = cnt_next < duty_d;
                busy_d   = 1'b1;
            end
            StRun: begin
                bridge_d = dir_d;
                pwm_d    = cnt_next < duty_d;
            end
            StDead: begin
                busy_d = 1'b1;
`ifdef MOTOR_BRAKE_EN
                bridge_d = DIR_BRAKE;
                pwm_d    = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            duty_q  <= '0;
            dir_q   <= DIR_OFF;
            dead_q  <= '0;
            pwm     <= 1'b0;
            bridge  <= DIR_OFF;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            pwm     <= pwm_d;
            bridge  <= bridge_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: rtl/motor_pwm_ramp.sv
// Two-channel H-bridge driver: shared PWM counter and ramp prescaler,
// per-channel ramp/dead-time control in motor_pwm_chan.
// Optional build macro MOTOR_BRAKE_EN selects active braking during dead time.
module motor_pwm_ramp
    import motor_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned RAMP_DIV    = 4,
    parameter int unsigned RAMP_STEP   = 16,
    parameter int unsigned DEAD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_a_in,
    input  logic             en_b_in,
    input  logic [3:0]       dir_in,
    input  logic [CNT_W-1:0] duty_target,
    output logic             pwm_a,
    output logic             pwm_b,
    output logic [3:0]       hb_out,
    output logic             busy_a,
    output logic             busy_b
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [1:0]       bridge_a, bridge_b;

    assign cnt_next = cnt_q + CNT_W'(1);
    assign tick     = (div_q == DIV_W'(RAMP_DIV - 1));
    assign div_d    = tick ? '0 : div_q + DIV_W'(1);
    assign hb_out   = {bridge_a, bridge_b};

    // Free-running PWM counter and ramp prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_next;
            div_q <= div_d;
        end
    end

    motor_pwm_chan #(
        .CNT_W       (CNT_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_a_in),
        .pair_req    (dir_in[3:2]),
        .duty_target (duty_target),
        .tick        (tick),
        .cnt_next    (cnt_next),
        .pwm         (pwm_a),
        .bridge      (bridge_a),
        .busy        (busy_a)
    );

    motor_pwm_chan #(
        .CNT_W       (CNT_W),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_b_in),
        .pair_req    (dir_in[1:0]),
        .duty_target (duty_target),
        .tick        (tick),
        .cnt_next    (cnt_next),
        .pwm         (pwm_b),
        .bridge      (bridge_b),
        .busy        (busy_b)
    );

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Self-checking bench for motor_pwm_ramp: directed scenarios plus random
// request/target sequences, compared each cycle against a behavioural model.
module tb_motor_pwm_ramp;

    localparam int CNT_W       = 8;
    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 16;
    localparam int DEAD_CYCLES = 32;
    localparam int PERIOD      = 1 << CNT_W;

`ifdef MOTOR_BRAKE_EN
    localparam bit BRAKE = 1'b1;
`else
    localparam bit BRAKE = 1'b0;
`endif
    localparam logic [1:0] DEAD_PAIR = BRAKE ? 2'b11 : 2'b00;

    // Model channel modes.
    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en_a_in = 1'b0;
    logic             en_b_in = 1'b0;
    logic [3:0]       dir_in = 4'b0000;
    logic [CNT_W-1:0] duty_target = '0;
    logic             pwm_a, pwm_b, busy_a, busy_b;
    logic [3:0]       hb_out;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, plus per-channel mode/duty/dir/dead.
    int n;
    int m_st[2];
    int m_duty[2];
    int m_dir[2];
    int m_dead[2];

    int  hi, k;
    bit  found;

    always #5 clk = ~clk;

    motor_pwm_ramp #(
        .CNT_W       (CNT_W),
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_a_in     (en_a_in),
        .en_b_in     (en_b_in),
        .dir_in      (dir_in),
        .duty_target (duty_target),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .hb_out      (hb_out),
        .busy_a      (busy_a),
        .busy_b      (busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] outvec();
        return {hb_out, pwm_a, pwm_b, busy_a, busy_b};
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [1:0] br[2];
        logic       pw[2];
        logic       bz[2];
        int         cnt;
        cnt = n % PERIOD;
        for (int c = 0; c < 2; c++) begin
            br[c] = 2'b00;
            pw[c] = 1'b0;
            bz[c] = 1'b0;
            if (m_st[c] == M_RAMP || m_st[c] == M_RUN) begin
                br[c] = 2'(m_dir[c]);
                pw[c] = cnt < m_duty[c];
            end else if (m_st[c] == M_DEAD) begin
                br[c] = DEAD_PAIR;
                pw[c] = BRAKE;
            end
            bz[c] = (m_st[c] == M_RAMP) || (m_st[c] == M_DEAD);
        end
        return {br[0], br[1], pw[0], pw[1], bz[0], bz[1]};
    endfunction

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < 2; c++) begin
            m_st[c]   = M_IDLE;
            m_duty[c] = 0;
            m_dir[c]  = 0;
            m_dead[c] = 0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit tick;
        tick = (n % RAMP_DIV) == (RAMP_DIV - 1);
        for (int c = 0; c < 2; c++) begin
            bit       req;
            logic [1:0] p;
            int       tgt;
            p   = (c == 0) ? dir_in[3:2] : dir_in[1:0];
            req = ((c == 0) ? en_a_in : en_b_in) && (p == 2'b10 || p == 2'b01);
            tgt = int'(duty_target);
            case (m_st[c])
                M_IDLE: if (req) begin
                    m_st[c] = M_RAMP;
                    m_dir[c] = int'(p);
                    m_duty[c] = 0;
                end
                M_RAMP, M_RUN: begin
                    if (!req) begin
                        m_st[c] = M_IDLE;
                        m_duty[c] = 0;
                    end else if (int'(p) != m_dir[c]) begin
                        m_st[c] = M_DEAD;
                        m_duty[c] = 0;
                        m_dead[c] = DEAD_CYCLES;
                    end else if (m_st[c] == M_RAMP) begin
                        if (m_duty[c] == tgt) m_st[c] = M_RUN;
                        else if (tick)
                            m_duty[c] = (m_duty[c] + RAMP_STEP < tgt) ? m_duty[c] + RAMP_STEP : tgt;
                    end else begin
                        if (tgt > m_duty[c]) m_st[c] = M_RAMP;
                        else if (tgt < m_duty[c]) m_duty[c] = tgt;
                    end
                end
                default: begin
                    m_dead[c] = m_dead[c] - 1;
                    if (m_dead[c] == 0) begin
                        if (req) begin
                            m_st[c] = M_RAMP;
                            m_dir[c] = int'(p);
                        end else begin
                            m_st[c] = M_IDLE;
                        end
                    end
                end
            endcase
        end
        n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("cycle_outputs", 32'(outvec()), 32'(exp_vec()));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_clear", 32'(outvec()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", 32'(outvec()), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic count_pwm_a(output int highs);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            highs += int'(pwm_a);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        run(4);

        // Forward ramp to 128 on channel A.
        en_a_in = 1'b1; dir_in = 4'b1000; duty_target = 8'd128;
        step();
        check_val("fwd_hb_latency", 32'(hb_out), 32'h8);
        check_val("fwd_busy", 32'(busy_a), 32'd1);
        run(40);
        check_val("fwd_run_not_busy", 32'(busy_a), 32'd0);
        count_pwm_a(hi);
        check_val("run_pwm_a_128", hi, 128);

        // Target change in RUN: down is immediate, up ramps and saturates.
        duty_target = 8'd64;
        step();
        count_pwm_a(hi);
        check_val("run_pwm_a_64", hi, 64);
        duty_target = 8'd250;
        run(80);
        count_pwm_a(hi);
        check_val("run_pwm_a_250", hi, 250);

        // Reversal from RUN: dead interval then ramp in the new direction.
        duty_target = 8'd128;
        dir_in = 4'b0100;
        step();
        check_val("rev_dead_pair", 32'(hb_out[3:2]), 32'(DEAD_PAIR));
        check_val("rev_dead_pwm", 32'(pwm_a), 32'(BRAKE));
        k = 0;
        while (hb_out[3:2] == DEAD_PAIR && k < 100) begin
            k++;
            step();
        end
        check_val("rev_dead_len", k, DEAD_CYCLES);
        check_val("rev_new_dir", 32'(hb_out[3:2]), 32'h1);
        run(50);

        // Disable mid-ramp at duty 48: straight to idle, no dead interval.
        en_a_in = 1'b0;
        run(3);
        en_a_in = 1'b1; dir_in = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_st[0] == M_RAMP && m_duty[0] == 48) begin
                found = 1'b1;
                break;
            end
        end
        check_val("reach_duty_48", 32'(found), 32'd1);
        en_a_in = 1'b0;
        step();
        check_val("off_hb_a", 32'(hb_out[3:2]), 32'd0);
        check_val("off_pwm_a", 32'(pwm_a), 32'd0);
        check_val("off_busy_a", 32'(busy_a), 32'd0);
        run(4);

        // Invalid pair keeps channel idle.
        en_a_in = 1'b1; dir_in = 4'b1100;
        run(10);
        check_val("invalid_idle", 32'({hb_out[3:2], busy_a}), 32'd0);

        // Both channels forward together.
        en_a_in = 1'b1; en_b_in = 1'b1; dir_in = 4'b1010; duty_target = 8'd200;
        run(80);
        check_val("both_run", 32'(outvec() & 8'hF3), 32'hA0);

        // Zero target: RUN with the pair driven and pwm constantly low.
        en_b_in = 1'b0; en_a_in = 1'b0;
        run(2);
        en_a_in = 1'b1; dir_in = 4'b0100; duty_target = 8'd0;
        run(PERIOD);
        check_val("zero_target_pair", 32'({hb_out[3:2], busy_a, pwm_a}), 32'h4);

        // Asynchronous reset mid-operation, then restart with inputs held.
        duty_target = 8'd180; en_b_in = 1'b1; dir_in = 4'b0110;
        run(30);
        do_reset();
        run(60);

        // Random request/direction/target sequences on both channels.
        for (int seg = 0; seg < 40; seg++) begin
            int pick;
            en_a_in = ($urandom_range(0, 3) != 0);
            en_b_in = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 2; c++) begin
                logic [1:0] p;
                pick = $urandom_range(0, 9);
                p = (pick < 4) ? 2'b10 : (pick < 8) ? 2'b01 : (pick == 8) ? 2'b00 : 2'b11;
                if (c == 0) dir_in[3:2] = p;
                else dir_in[1:0] = p;
            end
            pick = $urandom_range(0, 5);
            duty_target = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            run($urandom_range(1, 90));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
